// File: rtl/adc_edge_trigger.sv
`default_nettype none
// ============================================================================
// Module   : adc_edge_trigger
// Purpose  : Edge-triggered capture of a signed ADC sample stream into one
//            fixed-length AXI4-Stream packet terminated by TLAST.
// Revision : 1.0 - initial release
// ============================================================================
module adc_edge_trigger #(
    parameter int CAPTURE_LEN = 1024
) (
    input  logic       aclk,
    input  logic       aresetn,
    input  logic [7:0] s_axis_tdata,
    input  logic       s_axis_tvalid,
    output logic       s_axis_tready,
    input  logic       s_axis_tlast,
    output logic [7:0] m_axis_tdata,
    output logic       m_axis_tvalid,
    input  logic       m_axis_tready,
    output logic       m_axis_tlast,
    input  logic       arm,
    input  logic       disarm,
    input  logic       force_trig,
    input  logic       continuous,
    input  logic       trig_edge,
    input  logic [7:0] trig_level,
    output logic [1:0] state,
    output logic       trig_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARMED   = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DRAIN   = 2'd3
    } state_t;

    localparam logic [15:0] LEN = 16'(CAPTURE_LEN);

    state_t             cur_state;
    state_t             nxt_state;
    logic               enter_armed;

    logic               edge_sel;
    logic signed [7:0]  level;
    logic signed [7:0]  prev;
    logic               prev_ok;
    logic [15:0]        count;

    logic signed [7:0]  cur;
    logic [15:0]        count_inc;
    logic               s_hs;
    logic               m_hs;
    logic               crossing;
    logic               trig;
    logic               load;
    logic               load_last;

    // Upstream framing has no meaning for trigger framing.
    logic               unused_tlast;
    assign unused_tlast = s_axis_tlast;

    assign cur       = $signed(s_axis_tdata);
    assign count_inc = count + 16'd1;

    assign s_axis_tready = (cur_state == ST_ARMED) ||
                           ((cur_state == ST_CAPTURE) && (!m_axis_tvalid || m_axis_tready));
    assign s_hs = s_axis_tvalid && s_axis_tready;
    assign m_hs = m_axis_tvalid && m_axis_tready;

    assign crossing = prev_ok && (edge_sel ? ((prev > level) && (cur <= level))
                                           : ((prev < level) && (cur >= level)));
    // disarm wins over a trigger arriving in the same cycle.
    assign trig      = (cur_state == ST_ARMED) && s_hs && !disarm && (force_trig || crossing);
    assign load      = trig || ((cur_state == ST_CAPTURE) && s_hs);
    assign load_last = trig ? (LEN == 16'd1) : (count_inc == LEN);

    assign state = cur_state;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cur_state <= ST_IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state   = cur_state;
        enter_armed = 1'b0;
        case (cur_state)
            ST_IDLE: begin
                if (arm) begin
                    nxt_state   = ST_ARMED;
                    enter_armed = 1'b1;
                end
            end
            ST_ARMED: begin
                if (disarm) begin
                    nxt_state = ST_IDLE;
                end else if (trig) begin
                    nxt_state = (LEN == 16'd1) ? ST_DRAIN : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (s_hs && (count_inc == LEN)) begin
                    nxt_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (m_hs && m_axis_tlast) begin
                    if (continuous) begin
                        nxt_state   = ST_ARMED;
                        enter_armed = 1'b1;
                    end else begin
                        nxt_state = ST_IDLE;
                    end
                end
            end
            default: nxt_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            edge_sel      <= 1'b0;
            level         <= 8'sd0;
            prev          <= 8'sd0;
            prev_ok       <= 1'b0;
            count         <= 16'd0;
            trig_pulse    <= 1'b0;
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= 8'd0;
            m_axis_tlast  <= 1'b0;
        end else begin
            trig_pulse <= trig;

            // Config is sampled only when (re)entering ARMED.
            if (enter_armed) begin
                edge_sel <= trig_edge;
                level    <= $signed(trig_level);
                prev_ok  <= 1'b0;
            end else if ((cur_state == ST_ARMED) && s_hs) begin
                prev    <= cur;
                prev_ok <= 1'b1;
            end

            if (trig) begin
                count <= 16'd1;
            end else if ((cur_state == ST_CAPTURE) && s_hs) begin
                count <= count_inc;
            end

            if (load) begin
                m_axis_tvalid <= 1'b1;
                m_axis_tdata  <= s_axis_tdata;
                m_axis_tlast  <= load_last;
            end else if (m_hs) begin
                m_axis_tvalid <= 1'b0;
                m_axis_tlast  <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_adc_edge_trigger.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_edge_trigger
// Purpose  : Self-checking bench for adc_edge_trigger (packet model + timing).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_edge_trigger;

    localparam int LEN = 4;

    logic       aclk = 1'b0;
    logic       aresetn;
    logic [7:0] s_tdata;
    logic       s_tvalid;
    logic       s_tready;
    logic       s_tlast;
    logic [7:0] m_tdata;
    logic       m_tvalid;
    logic       m_tready;
    logic       m_tlast;
    logic       arm;
    logic       disarm;
    logic       force_trig;
    logic       continuous;
    logic       trig_edge;
    logic [7:0] trig_level;
    logic [1:0] state;
    logic       trig_pulse;

    logic [7:0] one_tdata;
    logic       one_tvalid;
    logic       one_tlast;
    logic       one_s_tready;
    logic [1:0] one_state;
    logic       one_pulse;

    adc_edge_trigger #(.CAPTURE_LEN(LEN)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready),
        .m_axis_tlast(m_tlast),
        .arm(arm), .disarm(disarm), .force_trig(force_trig), .continuous(continuous),
        .trig_edge(trig_edge), .trig_level(trig_level),
        .state(state), .trig_pulse(trig_pulse)
    );

    adc_edge_trigger #(.CAPTURE_LEN(1)) u_one (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(one_s_tready),
        .s_axis_tlast(s_tlast),
        .m_axis_tdata(one_tdata), .m_axis_tvalid(one_tvalid), .m_axis_tready(1'b1),
        .m_axis_tlast(one_tlast),
        .arm(arm), .disarm(disarm), .force_trig(force_trig), .continuous(continuous),
        .trig_edge(trig_edge), .trig_level(trig_level),
        .state(one_state), .trig_pulse(one_pulse)
    );

    always #5 aclk = ~aclk;

    int         total = 0;
    int         bad   = 0;
    byte        src_q[$];
    byte        acc_q[$];
    logic [8:0] out_q[$];
    logic [7:0] one_q[$];
    int         pulses;
    bit         rdy_rand;
    bit         vld_rand;
    bit         hold_v;
    logic [8:0] hold_beat;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic drive();
        s_tvalid = (src_q.size() > 0) && (!vld_rand || ($urandom_range(3) != 0));
        s_tdata  = (src_q.size() > 0) ? src_q[0] : 8'h00;
        s_tlast  = 1'($urandom_range(1));
        m_tready = !rdy_rand || ($urandom_range(1) == 1);
    endtask

    // Observe at the falling edge, then advance past the next rising edge.
    task automatic tick();
        bit popped;
        @(negedge aclk);
        popped = s_tvalid && s_tready;
        if (popped) acc_q.push_back(s_tdata);
        if (hold_v) begin
            chk("stall_valid", m_tvalid, 1'b1);
            chk("stall_beat", {m_tlast, m_tdata}, hold_beat);
        end
        hold_v    = m_tvalid && !m_tready;
        hold_beat = {m_tlast, m_tdata};
        if (m_tvalid && m_tready) out_q.push_back({m_tlast, m_tdata});
        if (one_tvalid) begin
            one_q.push_back(one_tdata);
            chk("one_last", one_tlast, 1'b1);
        end
        if (trig_pulse) pulses++;
        @(posedge aclk);
        #1;
        if (popped) void'(src_q.pop_front());
        arm    = 1'b0;
        disarm = 1'b0;
        drive();
    endtask

    task automatic start();
        src_q.delete();
        acc_q.delete();
        out_q.delete();
        one_q.delete();
        pulses = 0;
        hold_v = 1'b0;
    endtask

    task automatic ramp(int lo, int hi);
        for (int v = lo; v <= hi; v++) src_q.push_back(byte'(v));
    endtask

    function automatic bit crosses(bit e, int lvl, int p, int c);
        return e ? ((p > lvl) && (c <= lvl)) : ((p < lvl) && (c >= lvl));
    endfunction

    // Reference: split the accepted-sample stream into packets by rule.
    task automatic check_packets(string tag, bit e, int lvl, bit frc, bit cont);
        logic [8:0] exp_q[$];
        int idx = 0;
        int t;
        while (idx < acc_q.size()) begin
            t = frc ? idx : idx + 1;
            while (!frc && (t < acc_q.size()) && !crosses(e, lvl, acc_q[t-1], acc_q[t])) t++;
            if (t + LEN > acc_q.size()) break;
            for (int k = 0; k < LEN; k++) exp_q.push_back({(k == LEN - 1), acc_q[t+k]});
            idx = t + LEN;
            if (!cont) break;
        end
        chk({tag, "_beats"}, out_q.size(), exp_q.size());
        for (int k = 0; (k < exp_q.size()) && (k < out_q.size()); k++)
            chk({tag, "_beat"}, out_q[k], exp_q[k]);
        if (!cont && (exp_q.size() > 0)) begin
            chk({tag, "_one_cnt"}, one_q.size(), 1);
            if (one_q.size() > 0) chk({tag, "_one_data"}, one_q[0], exp_q[0][7:0]);
        end
    endtask

    task automatic run_until_idle(string tag, int max);
        int n = 0;
        while ((state != 2'd0) && (n < max)) begin
            tick();
            n++;
        end
        chk({tag, "_idle"}, state, 2'd0);
    endtask

    task automatic single_shot(string tag, bit e, int lvl, bit frc);
        trig_edge  = e;
        trig_level = lvl[7:0];
        force_trig = frc;
        continuous = 1'b0;
        arm = 1'b1;
        tick();
        // Config changes while armed must not matter.
        trig_edge  = !e;
        trig_level = ~lvl[7:0];
        run_until_idle(tag, 400);
        check_packets(tag, e, lvl, frc, 1'b0);
        chk({tag, "_pulses"}, pulses, 1);
        force_trig = 1'b0;
    endtask

    task automatic check_reset_outputs(string tag);
        chk({tag, "_mvalid"}, m_tvalid, 1'b0);
        chk({tag, "_mdata"}, m_tdata, 8'd0);
        chk({tag, "_mlast"}, m_tlast, 1'b0);
        chk({tag, "_sready"}, s_tready, 1'b0);
        chk({tag, "_state"}, state, 2'd0);
        chk({tag, "_pulse"}, trig_pulse, 1'b0);
        chk({tag, "_one_state"}, one_state, 2'd0);
        chk({tag, "_one_pulse"}, one_pulse, 1'b0);
        chk({tag, "_one_sready"}, one_s_tready, 1'b0);
    endtask

    initial begin
        int n;
        int lvl;
        bit e;

        aresetn = 1'b0; arm = 1'b0; disarm = 1'b0; force_trig = 1'b0;
        continuous = 1'b0; trig_edge = 1'b0; trig_level = 8'd0;
        rdy_rand = 1'b0; vld_rand = 1'b0;
        start();
        drive();
        repeat (3) tick();
        check_reset_outputs("reset");
        aresetn = 1'b1;
        tick();

        // Rising ramp through zero, with explicit latency checks.
        start();
        ramp(-3, 3);
        tick();
        chk("idle_sready", s_tready, 1'b0);
        trig_edge = 1'b0; trig_level = 8'd0; continuous = 1'b0;
        arm = 1'b1;
        tick();
        chk("arm_state", state, 2'd1);
        chk("arm_sready", s_tready, 1'b1);
        n = 0;
        while (!trig_pulse && (n < 20)) begin
            tick();
            n++;
        end
        chk("trig_seen", trig_pulse, 1'b1);
        chk("trig_valid", m_tvalid, 1'b1);
        chk("trig_data", m_tdata, 8'd0);
        chk("trig_state", state, 2'd2);
        run_until_idle("ramp", 50);
        check_packets("ramp", 1'b0, 0, 1'b0, 1'b0);
        chk("ramp_pulses", pulses, 1);

        // Falling with equal-to-level sample, then rising onto the level.
        start();
        src_q = '{20, 15, 10, 5, 0, -5};
        single_shot("fall10", 1'b1, 10, 1'b0);
        start();
        src_q = '{5, 9, 10, 10, 20, 30, 40};
        single_shot("rise10", 1'b0, 10, 1'b0);
        start();
        src_q = '{-7, -7, 0, -7, -7, -8, -9, -10};
        single_shot("fallneg", 1'b1, -7, 1'b0);

        // Output backpressure and input gaps.
        start();
        rdy_rand = 1'b1; vld_rand = 1'b1;
        ramp(-5, 30);
        single_shot("bp", 1'b0, 0, 1'b0);
        rdy_rand = 1'b0; vld_rand = 1'b0;

        // Continuous capture on a square wave; trailing +100 after each
        // packet must not trigger because re-arm discards history.
        start();
        for (int p = 0; p < 6; p++) begin
            repeat (3) src_q.push_back(-8'sd100);
            repeat (5) src_q.push_back(8'sd100);
        end
        trig_edge = 1'b0; trig_level = 8'd0; continuous = 1'b1;
        arm = 1'b1;
        tick();
        n = 0;
        while (((src_q.size() > 0) || (state != 2'd1)) && (n < 300)) begin
            tick();
            n++;
        end
        chk("cont_drained", state, 2'd1);
        continuous = 1'b0;
        disarm = 1'b1;
        tick();
        chk("cont_disarm", state, 2'd0);
        check_packets("cont", 1'b0, 0, 1'b0, 1'b1);
        chk("cont_pulses", pulses, 6);

        // Forced trigger on a flat input.
        start();
        repeat (8) src_q.push_back(8'sd5);
        single_shot("force", 1'b0, 50, 1'b1);

        // disarm coincident with a crossing.
        start();
        src_q = '{-1, 0, 1, 2, 3, 4};
        trig_edge = 1'b0; trig_level = 8'd0;
        arm = 1'b1;
        tick();
        tick();
        disarm = 1'b1;
        tick();
        tick();
        chk("disarm_state", state, 2'd0);
        chk("disarm_beats", out_q.size(), 0);
        chk("disarm_one", one_q.size(), 0);
        chk("disarm_pulses", pulses, 0);

        // Reset in the middle of a packet, then a fresh capture.
        start();
        ramp(-2, 10);
        arm = 1'b1;
        tick();
        n = 0;
        while (!trig_pulse && (n < 20)) begin
            tick();
            n++;
        end
        tick();
        tick();
        chk("mid_beat3", m_tdata, 8'd2);
        aresetn = 1'b0;
        tick();
        check_reset_outputs("midrst");
        aresetn = 1'b1;
        start();
        ramp(-2, 10);
        single_shot("rearm", 1'b0, 0, 1'b0);

        // Randomized streams with a guaranteed crossing tail.
        for (int it = 0; it < 6; it++) begin
            start();
            e   = 1'($urandom_range(1));
            lvl = int'($urandom_range(40)) - 20;
            rdy_rand = it[0];
            vld_rand = it[0];
            repeat (30) src_q.push_back(byte'(int'($urandom_range(50)) - 25));
            src_q.push_back(byte'(e ? lvl + 1 : lvl - 1));
            src_q.push_back(byte'(lvl));
            repeat (LEN) src_q.push_back(byte'(int'($urandom_range(50)) - 25));
            single_shot("rand", e, lvl, 1'b0);
        end
        rdy_rand = 1'b0;
        vld_rand = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
